// File: rtl/vec_checker.sv
// rtl/vec_checker.sv - vector-test sequencer for bit-slice ALU self-test
//
// Walks a vector index through a load/operate sequence, strobes the DUT,
// compares the masked DUT result with a reference word, counts mismatches
// and captures the first failing vector.
//
// Optional feature macro: VCHK_SIGNATURE_EN (result signature in sig).
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   begin a run (sampled in IDLE/DONE only)
//   halt_en   in   stop in HALT on a mismatch
//   cont      in   leave HALT
//   ref_word  in   reference word for the current vec (from ROM)
//   out       in   DUT result word
//   vec       out  current vector index
//   dut_ce    out  DUT clock enable (registered)
//   dut_ph    out  0 = load operand phase, 1 = operate phase
//   busy      out  run in progress, including HALT
//   done      out  run finished, sticky until next start
//   fail      out  at least one mismatch this run, sticky
//   halted    out  FSM in HALT
//   fail_cnt  out  saturating mismatch count
//   err_vec   out  index of first mismatch
//   err_xor   out  masked difference at first mismatch
//   sig       out  result signature (0 when the feature is disabled)

module vec_checker #(
   parameter int             VW     = 12,
   parameter int             RW     = 12,
   parameter int             NVEC   = 4095,
   parameter int             SETTLE = 1,
   parameter logic [RW-1:0]  MASK   = 'h3FF,
   parameter int             CW     = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          halt_en,
   input  logic          cont,
   input  logic [RW-1:0] ref_word,
   input  logic [RW-1:0] out,
   output logic [VW-1:0] vec,
   output logic          dut_ce,
   output logic          dut_ph,
   output logic          busy,
   output logic          done,
   output logic          fail,
   output logic          halted,
   output logic [CW-1:0] fail_cnt,
   output logic [VW-1:0] err_vec,
   output logic [RW-1:0] err_xor,
   output logic [15:0]   sig
);

   localparam logic [VW-1:0] LAST_VEC    = VW'(NVEC - 1);
   localparam int            SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_EXEC  = 3'd2,
      S_CHECK = 3'd3,
      S_STEP  = 3'd4,
      S_HALT  = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [SW-1:0] settle_cnt;
   logic [RW-1:0] diff;
   logic          mismatch;
   logic          run_start;

   logic ce_nxt;
   logic ph_nxt;
   logic busy_nxt;
   logic halted_nxt;
   logic done_nxt;

   assign diff      = (out ^ ref_word) & MASK;
   assign mismatch  = (diff != '0);
   assign run_start = ((state == S_IDLE) || (state == S_DONE)) && start;

   // State register; the strobe/status flags are registered from the next
   // state so they are glitch-free and line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         dut_ce <= 1'b0;
         dut_ph <= 1'b0;
         busy   <= 1'b0;
         halted <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_nxt;
         dut_ce <= ce_nxt;
         dut_ph <= ph_nxt;
         busy   <= busy_nxt;
         halted <= halted_nxt;
         done   <= done_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) state_nxt = S_LOAD;
         end
         S_LOAD: state_nxt = S_EXEC;
         S_EXEC: begin
            if (settle_cnt == SETTLE_LAST) state_nxt = S_CHECK;
         end
         S_CHECK: begin
            if (mismatch && halt_en) state_nxt = S_HALT;
            else                     state_nxt = S_STEP;
         end
         S_STEP: begin
            if (vec == LAST_VEC) state_nxt = S_DONE;
            else                 state_nxt = S_LOAD;
         end
         S_HALT: begin
            if (cont) state_nxt = S_STEP;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output decode of the upcoming state
   always_comb begin
      ce_nxt     = (state_nxt == S_LOAD) || (state_nxt == S_STEP);
      ph_nxt     = (state_nxt == S_EXEC) || (state_nxt == S_CHECK) ||
                   (state_nxt == S_STEP) || (state_nxt == S_HALT);
      busy_nxt   = (state_nxt == S_LOAD) || (state_nxt == S_EXEC) ||
                   (state_nxt == S_CHECK) || (state_nxt == S_STEP) ||
                   (state_nxt == S_HALT);
      halted_nxt = (state_nxt == S_HALT);
      done_nxt   = (state_nxt == S_DONE);
   end

   // EXEC dwell counter; held at zero outside EXEC so every vector gets
   // the full SETTLE cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt <= '0;
      end else if (state == S_EXEC && settle_cnt != SETTLE_LAST) begin
         settle_cnt <= settle_cnt + SW'(1);
      end else begin
         settle_cnt <= '0;
      end
   end

   // Vector index and run status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec      <= '0;
         fail     <= 1'b0;
         fail_cnt <= '0;
         err_vec  <= '0;
         err_xor  <= '0;
      end else if (run_start) begin
         vec      <= '0;
         fail     <= 1'b0;
         fail_cnt <= '0;
         err_vec  <= '0;
         err_xor  <= '0;
      end else begin
         if (state == S_CHECK && mismatch) begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + CW'(1);
            // Only the first failure of the run is captured.
            if (!fail) begin
               err_vec <= vec;
               err_xor <= diff;
               fail    <= 1'b1;
            end
         end
         if (state == S_STEP && vec != LAST_VEC) begin
            vec <= vec + VW'(1);
         end
      end
   end

`ifdef VCHK_SIGNATURE_EN
   // CRC-16/CCITT-style shift with the masked result folded in each CHECK.
   logic [15:0] sig_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_r <= '0;
      end else if (run_start) begin
         sig_r <= '0;
      end else if (state == S_CHECK) begin
         sig_r <= {sig_r[14:0], 1'b0} ^ (sig_r[15] ? 16'h1021 : 16'h0000) ^
                  16'(out & MASK);
      end
   end

   assign sig = sig_r;
`else
   assign sig = '0;
`endif

endmodule

// File: doc/vec_checker.md
# vec_checker

Synthesizable, parametrised vector-test sequencer for bit-slice ALU blocks such as am2901, for on-board self-test on the DE0 target. Walks a vector index through a two-phase load/operate sequence, drives DUT clock-enable and phase strobes, compares the masked DUT result against a reference word, counts mismatches and captures the first failure. It sits between a reference vector ROM, the DUT stimulus decode and a status/debug port.

## Interface
- `VW`, 12: vector index width.
- `RW`, 12: result/reference width, ≤16.
- `NVEC`, 4095: vectors per run, 1..2^VW.
- `SETTLE`, 1: EXEC-phase wait cycles, ≥1.
- `MASK`, 12'h3FF: compare mask; a 1 means the bit is checked.
- `CW`, 16: failure-counter width.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begins a run; level-sampled in IDLE/DONE only.
- `halt_en` in 1: stop in HALT on a mismatch.
- `cont` in 1: leave HALT.
- `ref` in RW: reference word for the current `vec`, combinational from ROM.
- `out` in RW: DUT result word.
- `vec` out VW: current vector index; feeds ROM address and DUT stimulus decode.
- `dut_ce` out 1: DUT clock enable for this cycle.
- `dut_ph` out 1: 0 = load operand phase, 1 = operate phase.
- `busy` out 1: run in progress, including HALT.
- `done` out 1: run finished; sticky until next `start`.
- `fail` out 1: at least one mismatch this run; sticky.
- `halted` out 1: FSM in HALT.
- `fail_cnt` out CW: mismatch count; saturates at all-ones.
- `err_vec` out VW: index of the first mismatch.
- `err_xor` out RW: `(out^ref)&MASK` at the first mismatch.
- `sig` out 16: result signature.

## Operation
- Reset: all outputs 0, FSM in IDLE.
- States: IDLE, LOAD, EXEC, CHECK, STEP, HALT, DONE.
- IDLE/DONE:
  - `start`=1 → LOAD.
  - Clears `vec`, `done`, `fail`, `fail_cnt`, `err_vec`, `err_xor` and `sig`.
- LOAD: `dut_ph`=0, `dut_ce`=1 (DUT latches operand), → EXEC.
- EXEC: `dut_ph`=1, `dut_ce`=0; remains SETTLE cycles, → CHECK.
- CHECK: `dut_ph`=1, `dut_ce`=0; computes `x=(out^ref)&MASK`.
  - x≠0:
    - `fail_cnt`+1, saturating.
    - If `fail` was 0: capture `err_vec`=`vec` and `err_xor`=x, then set `fail`.
    - Next state: HALT if `halt_en`, else STEP.
  - x=0 → STEP.
- STEP: `dut_ph`=1, `dut_ce`=1 (DUT commits operate cycle).
  - `vec`==NVEC-1 → DONE, `vec` holds.
  - Otherwise `vec`+1, → LOAD.
- HALT: `halted`=1, `dut_ce`=0, `vec` frozen; `cont`=1 → STEP. `start` is ignored here.
- DONE: `done`=1, `busy`=0.
- `busy`=1 in LOAD, EXEC, CHECK, STEP and HALT.
- `start` and `cont` outside their states are ignored.
- `rst_n` low mid-run aborts immediately to reset values. No partial status is retained.

## Timing
- Per vector without halt: SETTLE+3 cycles.
- Full run: NVEC×(SETTLE+3) cycles from the first LOAD; `done` rises the cycle after the last STEP.
- `start` seen at edge n → LOAD during cycle n+1.
- `ref`/`out` are sampled on the edge ending CHECK; they must be stable by then.
- Status registers update on that same edge.
- `dut_ce` is registered, glitch-free, exactly one cycle per phase.

## Configuration
- `VCHK_SIGNATURE_EN` defined: each CHECK updates `sig ← (sig<<1) ^ (sig[15] ? 16'h1021 : 0) ^ zext16(out&MASK)`. `sig` is cleared on `start` and reset.
- Not defined: `sig` is constant 0 and no signature logic is generated.

## Test plan
- NVEC=4, SETTLE=1, `out`=`ref`, `start` pulse:
  - `vec` steps 0,1,2,3; `dut_ce` pulses with `dut_ph`=0,1 per vector.
  - `done`=1 after 16 cycles; `fail`=0, `fail_cnt`=0.
- NVEC=4, `halt_en`=0, `out` bit0 inverted at vec 2:
  - `fail`=1, `fail_cnt`=1, `err_vec`=2, `err_xor`=12'h001, `done`=1.
- Same mismatch with `halt_en`=1:
  - `halted`=1, `busy`=1, `vec`=2 held.
  - `cont` pulse → STEP; `done` after the remaining vector.
- Mismatch only in bit 10 with MASK=12'h3FF: `fail`=0, `fail_cnt`=0.
- Assert `rst_n`=0 during EXEC of vec 1:
  - All outputs 0 immediately.
  - A new `start` runs cleanly from vec 0.
- With `VCHK_SIGNATURE_EN`, NVEC=2, `out`=`ref`=`vec`: final `sig`=16'h0001. Without the macro, `sig`=0.
